// File: rtl/echo_pkg.sv
// rtl/echo_pkg.sv - sample type, FSM states and saturation helper for the echo stage
package echo_pkg;

   localparam int DATA_W = 16;

   typedef logic signed [DATA_W-1:0] sample_t;

   typedef enum logic [2:0] {CLEAR, IDLE, READ, MIX, WRITE} state_t;

   // Overflow of a DATA_W+1 sum shows up as the top two bits disagreeing.
   function automatic sample_t sat(input logic signed [DATA_W:0] v);
      if (v[DATA_W] == v[DATA_W-1]) begin
         return v[DATA_W-1:0];
      end
      return v[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
   endfunction

endpackage

// File: rtl/echo_delay_ram.sv
// rtl/echo_delay_ram.sv - single-port delay buffer, synchronous read, one-cycle latency
module echo_delay_ram
   import echo_pkg::*;
#(
   parameter int DEPTH = 4096,
   parameter int WIDTH = DATA_W,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/echo_effect.sv
// rtl/echo_effect.sv - delay-line echo: buffer clear, read/mix/write FSM, saturating feedback mix
module echo_effect
   import echo_pkg::*;
#(
   parameter int DEPTH = 4096
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] Signal_in,
   input  logic              enable,
   input  logic              delay_sel,
   output logic [DATA_W-1:0] Signal_out,
   output logic              out_valid,
   output logic              busy,
   output logic              overrun
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW-1:0] DLY_SHORT = AW'(DEPTH / 2);
   localparam logic [AW-1:0] DLY_LONG  = AW'(DEPTH - 1);

   state_t state, state_nx;

   logic [AW-1:0]     wr_ptr, clr_cnt, rd_addr;
   logic              en_q, dsel_q;
   sample_t           in_q, wet_q, fb_q;
   sample_t           d, d_half, d_quarter;
   logic signed [DATA_W:0] wet_sum, fb_sum;

   logic              ram_we;
   logic [AW-1:0]     ram_addr;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;

   assign busy    = (state != IDLE);
   assign rd_addr = wr_ptr - (dsel_q ? DLY_LONG : DLY_SHORT);

   assign d         = ram_rdata;
   assign d_half    = d >>> 1;
   assign d_quarter = d >>> 2;
   assign wet_sum   = {in_q[DATA_W-1], in_q} + {d_half[DATA_W-1], d_half};
   assign fb_sum    = {in_q[DATA_W-1], in_q} + {d_quarter[DATA_W-1], d_quarter};

   always_comb begin
      state_nx = state;
      case (state)
         CLEAR:   if (clr_cnt == LAST_ADDR) state_nx = IDLE;
         IDLE:    if (sample_valid) state_nx = READ;
         READ:    state_nx = MIX;
         MIX:     state_nx = WRITE;
         WRITE:   state_nx = IDLE;
         default: state_nx = CLEAR;
      endcase
   end

   // Single RAM port: clear and write-back own it for writes, READ for the delayed tap.
   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = rd_addr;
      ram_wdata = '0;
      case (state)
         CLEAR: begin
            ram_we   = 1'b1;
            ram_addr = clr_cnt;
         end
         WRITE: begin
            ram_we    = 1'b1;
            ram_addr  = wr_ptr;
            ram_wdata = en_q ? fb_q : in_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= CLEAR;
         clr_cnt    <= '0;
         wr_ptr     <= '0;
         in_q       <= '0;
         en_q       <= 1'b0;
         dsel_q     <= 1'b0;
         wet_q      <= '0;
         fb_q       <= '0;
         Signal_out <= '0;
         out_valid  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state     <= state_nx;
         out_valid <= (state == WRITE);
         overrun   <= sample_valid && (state == READ || state == MIX || state == WRITE);
         if (state == CLEAR) begin
            clr_cnt <= clr_cnt + AW'(1);
         end
         if (state == IDLE && sample_valid) begin
            in_q   <= Signal_in;
            en_q   <= enable;
            dsel_q <= delay_sel;
         end
         if (state == MIX) begin
            wet_q <= sat(wet_sum);
            fb_q  <= sat(fb_sum);
         end
         if (state == WRITE) begin
            wr_ptr     <= wr_ptr + AW'(1);
            Signal_out <= en_q ? wet_q : in_q;
         end
      end
   end

   echo_delay_ram #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_W)
   ) u_ram (
      .CLK   (CLK),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

endmodule
